aes_key_expansion_iter: RTL and testbench

- Iterative, multi-mode AES key expander for AES-128, AES-192 and AES-256, selected per key at run time.
- Accepts one cipher key over a valid/ready handshake and emits the full round-key sequence (Nr+1 keys of 128 bits) over a second valid/ready handshake.
- Computes one schedule word per cycle with a single 4-S-box datapath and feeds the iterative encrypt/decrypt cores that do not hold a fully unrolled schedule.

---
 rtl/aes_key_expansion_iter.sv | 170 +++++++++++++++++
 tb/tb_aes_key_expansion_iter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expansion_iter.sv
// rtl/aes_key_expansion_iter.sv - iterative AES-128/192/256 key expander, one schedule word per cycle
module aes_key_expansion_iter #(
  parameter int MAX_KEY_LENGTH = 256
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      In_valid,
  output logic                      In_ready,
  input  logic [1:0]                Key_mode,
  input  logic [MAX_KEY_LENGTH-1:0] Input_key,
  output logic                      Out_valid,
  input  logic                      Out_ready,
  output logic [127:0]              Output_key,
  output logic [3:0]                Round_index,
  output logic                      Last,
  output logic                      Key_error
);

  localparam int NMAX = MAX_KEY_LENGTH / 32;

  typedef enum logic [1:0] {IDLE, GEN, OUT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   key_q [NMAX];
  logic [31:0]   win_q [NMAX];
  logic [127:0]  buf_q;
  logic [5:0]    i_q;
  logic [3:0]    modc_q;
  logic [7:0]    rcon_q;
  logic [3:0]    nk_q, nr_q, round_q;
  logic          key_error_q;

  logic [3:0]    mode_nk, mode_nr;
  logic          mode_legal;
  logic [31:0]   key_word, w_prev, w_old, sub_in, sub_out, new_word;
  logic          past_key;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Decode requested mode; a mode wider than the synthesized window is rejected
  always_comb begin
    mode_nk = 4'd4;
    mode_nr = 4'd10;
    case (Key_mode)
      2'b01:   begin mode_nk = 4'd6; mode_nr = 4'd12; end
      2'b10:   begin mode_nk = 4'd8; mode_nr = 4'd14; end
      2'b11:   begin mode_nk = 4'd8; mode_nr = 4'd14; end
      default: begin mode_nk = 4'd4; mode_nr = 4'd10; end
    endcase
    mode_legal = (Key_mode != 2'b11) && ((32 * int'(mode_nk)) <= MAX_KEY_LENGTH);
  end

  // Schedule word for position i from the key or from the sliding window
  always_comb begin
    key_word = 32'h0;
    w_old    = 32'h0;
    for (int j = 0; j < NMAX; j++) begin
      if (i_q == 6'(j)) key_word = key_q[j];
      if (nk_q == 4'(j + 1)) w_old = win_q[j];
    end
    w_prev   = win_q[0];
    past_key = (i_q >= {2'b00, nk_q});
    sub_in   = (modc_q == 4'd0) ? {w_prev[7:0], w_prev[31:8]} : w_prev;
    sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (!past_key)
      new_word = key_word;
    else if (modc_q == 4'd0)
      new_word = w_old ^ sub_out ^ {24'h0, rcon_q};
    else if ((nk_q == 4'd8) && (modc_q == 4'd4))
      new_word = w_old ^ sub_out;
    else
      new_word = w_old ^ w_prev;
  end

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: four words per GEN visit, then hold in OUT until accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (In_valid && mode_legal) state_d = GEN;
      GEN:     if (i_q[1:0] == 2'd3) state_d = OUT;
      OUT:     if (Out_ready) state_d = (round_q == nr_q) ? IDLE : GEN;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    In_ready    = (state_q == IDLE);
    Out_valid   = (state_q == OUT);
    Last        = (state_q == OUT) && (round_q == nr_q);
    Output_key  = buf_q;
    Round_index = round_q;
    Key_error   = key_error_q;
  end

  // Key latch, word generation, window shift and round counting
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int j = 0; j < NMAX; j++) begin
        key_q[j] <= 32'h0;
        win_q[j] <= 32'h0;
      end
      buf_q       <= 128'h0;
      i_q         <= 6'd0;
      modc_q      <= 4'd0;
      rcon_q      <= 8'h00;
      nk_q        <= 4'd0;
      nr_q        <= 4'd0;
      round_q     <= 4'd0;
      key_error_q <= 1'b0;
    end else begin
      key_error_q <= (state_q == IDLE) && In_valid && !mode_legal;
      case (state_q)
        IDLE: begin
          if (In_valid && mode_legal) begin
            nk_q <= mode_nk;
            nr_q <= mode_nr;
            for (int j = 0; j < NMAX; j++) key_q[j] <= Input_key[32*j +: 32];
            i_q     <= 6'd0;
            modc_q  <= 4'd0;
            rcon_q  <= 8'h01;
            round_q <= 4'd0;
          end
        end
        GEN: begin
          buf_q[{i_q[1:0], 5'b00000} +: 32] <= new_word;
          win_q[0] <= new_word;
          for (int j = 1; j < NMAX; j++) win_q[j] <= win_q[j-1];
          i_q    <= i_q + 6'd1;
          modc_q <= (modc_q == nk_q - 4'd1) ? 4'd0 : modc_q + 4'd1;
          if (past_key && (modc_q == 4'd0))
            rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
        OUT: begin
          if (Out_ready && (round_q != nr_q)) round_q <= round_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expansion_iter.sv
// tb/tb_aes_key_expansion_iter.sv - scoreboard bench for aes_key_expansion_iter
module tb_aes_key_expansion_iter;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         In_valid = 1'b0;
  logic         In_ready;
  logic [1:0]   Key_mode = 2'b00;
  logic [255:0] Input_key = '0;
  logic         Out_valid;
  logic         Out_ready = 1'b1;
  logic [127:0] Output_key;
  logic [3:0]   Round_index;
  logic         Last;
  logic         Key_error;

  logic         iv128 = 1'b0;
  logic [127:0] key128 = '0;
  logic         rdy128 = 1'b1;
  logic         In_ready128, Out_valid128, Last128, Key_error128;
  logic [127:0] Output_key128;
  logic [3:0]   Round_index128;

  always #5 Clk = ~Clk;

  aes_key_expansion_iter #(.MAX_KEY_LENGTH(256)) u_dut (
    .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .In_ready(In_ready),
    .Key_mode(Key_mode), .Input_key(Input_key), .Out_valid(Out_valid),
    .Out_ready(Out_ready), .Output_key(Output_key), .Round_index(Round_index),
    .Last(Last), .Key_error(Key_error)
  );

  aes_key_expansion_iter #(.MAX_KEY_LENGTH(128)) u_dut128 (
    .Clk(Clk), .Rst(Rst), .In_valid(iv128), .In_ready(In_ready128),
    .Key_mode(Key_mode), .Input_key(key128), .Out_valid(Out_valid128),
    .Out_ready(rdy128), .Output_key(Output_key128), .Round_index(Round_index128),
    .Last(Last128), .Key_error(Key_error128)
  );

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
    logic         last;
  } exp_t;

  exp_t         sbq[$];
  int           tests = 0;
  int           fails = 0;
  int           cycle = 0;
  int           rdy_mode = 0;
  bit           chk_spacing = 1'b1;
  int           acc_cycle = 0;
  int           accept_cnt = 0;
  int           done_cnt = 0;
  int           hs_total = 0;
  logic [127:0] cap [16];
  logic [7:0]   sbox_t [256];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 0) begin
      if (y[0]) r ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [255:0] rev(input logic [255:0] v, input int nb);
    logic [255:0] o = '0;
    for (int j = 0; j < nb; j++) o[8*j +: 8] = v[8*(nb-1-j) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] rk(input logic [127:0] v);
    logic [127:0] o;
    for (int j = 0; j < 16; j++) o[8*j +: 8] = v[8*(15-j) +: 8];
    return o;
  endfunction

  task automatic push_expected(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int          nr = nk + 6;
    exp_t        e;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = key[32*i +: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = m_subw({t[7:0], t[31:8]}) ^ {24'h0, rc};
          rc = m_mul(rc, 8'h02);
        end else if (nk == 8 && i % nk == 4) t = m_subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) begin
      e.key  = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
      e.idx  = 4'(r);
      e.last = (r == nr);
      sbq.push_back(e);
    end
  endtask

  task automatic send_key(input logic [1:0] mode, input logic [255:0] key, input int nk);
    int n = 0;
    while (!In_ready && n < 200) begin @(posedge Clk); #1; n++; end
    check("in_ready_before_send", 128'(In_ready), 128'(1));
    Key_mode  = mode;
    Input_key = key;
    In_valid  = 1'b1;
    push_expected(key, nk);
    @(posedge Clk);
    #1;
    In_valid   = 1'b0;
    acc_cycle  = cycle;
    accept_cnt = accept_cnt + 1;
  endtask

  task automatic wait_done(input string tag, input int nkeys, input int h0);
    int n = 0;
    while (done_cnt != accept_cnt && n < 3000) begin @(posedge Clk); n++; end
    check({tag, "_done"}, 128'(done_cnt == accept_cnt), 128'(1));
    check({tag, "_count"}, 128'(hs_total - h0), 128'(nkeys));
    check({tag, "_queue_empty"}, 128'(sbq.size()), 128'(0));
    #1;
  endtask

  initial forever begin
    @(posedge Clk);
    cycle <= cycle + 1;
  end

  initial forever begin
    @(posedge Clk);
    #1;
    Out_ready = (rdy_mode == 1) ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  // Monitor: handshake scoring, stall stability, busy In_ready
  initial begin
    exp_t         e;
    int           prev_hs = -1;
    bit           prev_stall = 1'b0;
    logic [127:0] s_key = '0;
    logic [3:0]   s_idx = '0;
    logic         s_last = 1'b0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        prev_hs    = -1;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 128'(Out_valid), 128'(1));
          check("stall_key", Output_key, s_key);
          check("stall_index", 128'(Round_index), 128'(s_idx));
          check("stall_last", 128'(Last), 128'(s_last));
        end
        if (Out_valid && Out_ready) begin
          if (sbq.size() == 0) check("unexpected_output", 128'(1), 128'(0));
          else begin
            e = sbq.pop_front();
            check("round_key", Output_key, e.key);
            check("round_index", 128'(Round_index), 128'(e.idx));
            check("last", 128'(Last), 128'(e.last));
            cap[Round_index] = Output_key;
            if (chk_spacing) begin
              if (prev_hs < 0) check("first_latency", 128'(cycle - acc_cycle), 128'(4));
              else             check("spacing", 128'(cycle - prev_hs), 128'(5));
            end
            hs_total = hs_total + 1;
            prev_hs  = e.last ? -1 : cycle;
            if (e.last) done_cnt = done_cnt + 1;
          end
        end else if (accept_cnt != done_cnt) begin
          check("in_ready_busy", 128'(In_ready), 128'(0));
        end
        prev_stall = Out_valid && !Out_ready;
        s_key  = Output_key;
        s_idx  = Round_index;
        s_last = Last;
      end
    end
  end

  initial begin
    logic [255:0] k128, k192, k256;
    logic [7:0]   inv, b;
    int           h0;
    int           n;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) if (m_mul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 0;
      sbox_t[x] = b;
    end

    k128 = rev(256'h2b7e151628aed2a6abf7158809cf4f3c, 16);
    k192 = rev(256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 24);
    k256 = rev(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 32);

    #1;
    check("reset_in_ready", 128'(In_ready), 128'(1));
    check("reset_out_valid", 128'(Out_valid), 128'(0));
    check("reset_last", 128'(Last), 128'(0));
    check("reset_key_error", 128'(Key_error), 128'(0));
    check("reset_output_key", Output_key, 128'h0);
    check("reset_round_index", 128'(Round_index), 128'(0));
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;

    // AES-128
    h0 = hs_total;
    send_key(2'b00, k128, 4);
    wait_done("aes128", 11, h0);
    check("aes128_r0", cap[0], k128[127:0]);
    check("aes128_r1", cap[1], rk(128'ha0fafe1788542cb123a339392a6c7605));
    check("aes128_r10", cap[10], rk(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

    // AES-192
    h0 = hs_total;
    send_key(2'b01, k192, 6);
    wait_done("aes192", 13, h0);
    check("aes192_r12", cap[12], rk(128'he98ba06f448c773c8ecc720401002202));

    // AES-256
    h0 = hs_total;
    send_key(2'b10, k256, 8);
    wait_done("aes256", 15, h0);
    check("aes256_r1", cap[1], rk(128'h1f352c073b6108d72d9810a30914dff4));
    check("aes256_r14", cap[14], rk(128'hfe4890d1e6188d0b046df344706c631e));

    // AES-256 under random backpressure
    chk_spacing = 1'b0;
    rdy_mode    = 1;
    h0 = hs_total;
    send_key(2'b10, k256, 8);
    wait_done("aes256_bp", 15, h0);
    check("aes256_bp_r14", cap[14], rk(128'hfe4890d1e6188d0b046df344706c631e));
    rdy_mode = 0;
    @(posedge Clk);
    #1;
    chk_spacing = 1'b1;

    // Illegal mode
    Key_mode = 2'b11;
    In_valid = 1'b1;
    @(posedge Clk);
    #1;
    In_valid = 1'b0;
    @(negedge Clk);
    check("kerr_pulse", 128'(Key_error), 128'(1));
    check("kerr_out_valid", 128'(Out_valid), 128'(0));
    check("kerr_in_ready", 128'(In_ready), 128'(1));
    @(negedge Clk);
    check("kerr_one_cycle", 128'(Key_error), 128'(0));
    check("kerr_out_valid_after", 128'(Out_valid), 128'(0));

    // 256-bit mode on a 128-bit build
    @(posedge Clk);
    #1;
    Key_mode = 2'b10;
    iv128    = 1'b1;
    @(posedge Clk);
    #1;
    iv128 = 1'b0;
    @(negedge Clk);
    check("k128_mode10_error", 128'(Key_error128), 128'(1));
    check("k128_mode10_in_ready", 128'(In_ready128), 128'(1));
    check("k128_mode10_out_valid", 128'(Out_valid128), 128'(0));
    check("k128_main_no_error", 128'(Key_error), 128'(0));
    @(negedge Clk);
    check("k128_mode10_one_cycle", 128'(Key_error128), 128'(0));

    // Async reset during round 5 of AES-128, then AES-192
    @(posedge Clk);
    #1;
    send_key(2'b00, k128, 4);
    n = 0;
    while (!(Round_index == 4'd5 && !Out_valid) && n < 200) begin @(negedge Clk); n++; end
    check("reach_round5", 128'(Round_index), 128'(5));
    #2;
    Rst = 1'b1;
    #1;
    check("rst_out_valid", 128'(Out_valid), 128'(0));
    check("rst_in_ready", 128'(In_ready), 128'(1));
    check("rst_round_index", 128'(Round_index), 128'(0));
    sbq.delete();
    accept_cnt = done_cnt;
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    h0 = hs_total;
    send_key(2'b01, k192, 6);
    wait_done("after_rst_aes192", 13, h0);
    check("after_rst_r12", cap[12], rk(128'he98ba06f448c773c8ecc720401002202));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
